// File: rtl/lsu_stage_if.sv
// Load/store stage bus bundle: execute-side request, memory bus, writeback result.
// The stage itself uses the slave modport; the environment drives through master.
interface lsu_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_we;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;

    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_fault;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_we, in_op, in_rd,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output out_valid, out_rdata, out_rd, out_fault,
        input  out_ready
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_we, in_op, in_rd,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  out_valid, out_rdata, out_rd, out_fault,
        output out_ready
    );
endinterface

// File: rtl/lsu_stage.sv
// Single-outstanding load/store stage: latches one request, runs one bus access,
// aligns/extends load data and hands the result to writeback.
// Optional feature: define LSU_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses without touching the bus.
module lsu_stage #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_stage_if.slave io
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(RESP_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [7:0]  cnt_q;

    logic        bad_op, misalign, reject, timeout_hit;
    logic [31:0] byte_sh, half_sh, load_data;

    // Requests that must fault immediately, never reaching the bus.
    always_comb begin
        bad_op = (io.in_op == 3'b011) || (io.in_op[2:1] == 2'b11) ||
                 (io.in_we && io.in_op[2]);
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((io.in_op[1:0] == 2'b01) && io.in_addr[0]) ||
                   ((io.in_op[1:0] == 2'b10) && (io.in_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        reject = bad_op || misalign;
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (io.in_valid) state_nxt = reject ? DONE : REQ;
            REQ:  if (io.mem_gnt) state_nxt = RESP;
            RESP: if (io.mem_rvalid || timeout_hit) state_nxt = DONE;
            DONE: if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and bus outputs; store lanes are placed from the latched request.
    always_comb begin
        io.in_ready  = (state == IDLE);
        io.mem_req   = (state == REQ);
        io.out_valid = (state == DONE);
        io.mem_we    = we_q;
        io.mem_addr  = {addr_q[31:2], 2'b00};
        io.mem_wdata = 32'h0;
        io.mem_wstrb = 4'h0;
        if (we_q) begin
            case (op_q[1:0])
                2'b00: begin
                    io.mem_wdata = {24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
                    io.mem_wstrb = 4'b0001 << addr_q[1:0];
                end
                2'b01: begin
                    io.mem_wdata = {16'h0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
                    io.mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                end
                default: begin
                    io.mem_wdata = wdata_q;
                    io.mem_wstrb = 4'b1111;
                end
            endcase
        end
        io.out_rdata = rdata_q;
        io.out_rd    = rd_q;
        io.out_fault = fault_q;
    end

    // Load alignment: pick the addressed byte/half, then sign or zero extend.
    always_comb begin
        byte_sh = io.mem_rdata >> {addr_q[1:0], 3'b000};
        half_sh = io.mem_rdata >> {addr_q[1], 4'b0000};
        case (op_q)
            3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  load_data = {24'h0, byte_sh[7:0]};
            3'b001:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  load_data = {16'h0, half_sh[15:0]};
            default: load_data = io.mem_rdata;
        endcase
    end

    // Request latch, response capture and response-timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            rd_q    <= 5'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    addr_q  <= io.in_addr;
                    wdata_q <= io.in_wdata;
                    we_q    <= io.in_we;
                    op_q    <= io.in_op;
                    rd_q    <= io.in_rd;
                    rdata_q <= 32'h0;
                    fault_q <= reject;
                end
                REQ: if (io.mem_gnt) cnt_q <= 8'h0;
                RESP: begin
                    if (io.mem_rvalid) begin
                        rdata_q <= we_q ? 32'h0 : load_data;
                        fault_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// Randomized + directed bench for lsu_stage against a transaction-level model.
module tb_lsu_stage;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lsu_stage_if bus();

    lsu_stage #(.RESP_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        busy = 1'b0;
    logic        chk_on = 1'b0;
    logic        exp_bus, exp_we, exp_fault;
    logic [31:0] exp_maddr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic [4:0]  exp_rd;
    int          req_cnt;
    logic [31:0] last_maddr, last_mwdata, last_ordata;
    logic [3:0]  last_mwstrb;
    logic        last_mwe, last_ofault;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: what the bus and the result must look like.
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [2:0] op, input logic [4:0] rd,
                         input logic [31:0] word, input int rvd);
        logic        illegal;
        logic [31:0] v;
        illegal = (op == 3) || (op == 6) || (op == 7) || (we && op[2]);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((op[1:0] == 2'd1 && a[0]) || (op[1:0] == 2'd2 && (a % 4) != 0)) illegal = 1'b1;
`endif
        exp_bus   = !illegal;
        exp_fault = illegal || (rvd >= TO);
        exp_we    = we;
        exp_rd    = rd;
        exp_maddr = a - (a % 4);
        exp_wdata = 32'h0;
        exp_wstrb = 4'h0;
        if (we) begin
            if (op[1:0] == 2'd0) begin
                exp_wdata = (wd & 32'hFF) << (8 * (a % 4));
                exp_wstrb = 4'(1 << (a % 4));
            end else if (op[1:0] == 2'd1) begin
                exp_wdata = (wd & 32'hFFFF) << (16 * ((a / 2) % 2));
                exp_wstrb = 4'(3 << (2 * ((a / 2) % 2)));
            end else begin
                exp_wdata = wd;
                exp_wstrb = 4'hF;
            end
        end
        case (op)
            3'd0: begin v = (word >> (8 * (a % 4))) & 32'hFF; if (v >= 128) v = v + 32'hFFFFFF00; end
            3'd4: v = (word >> (8 * (a % 4))) & 32'hFF;
            3'd1: begin v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd5: v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            default: v = word;
        endcase
        exp_rdata = (exp_fault || we) ? 32'h0 : v;
    endtask

    // Per-cycle compare of all meaningful outputs against the model.
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("in_ready", bus.in_ready, !busy);
            if (!busy) begin
                chk("idle_mem_req", bus.mem_req, 1'b0);
                chk("idle_out_valid", bus.out_valid, 1'b0);
            end else begin
                if (bus.mem_req) begin
                    req_cnt++;
                    chk("mem_req_expected", exp_bus, 1'b1);
                    chk("mem_addr", bus.mem_addr, exp_maddr);
                    chk("mem_we", bus.mem_we, exp_we);
                    chk("mem_wstrb", bus.mem_wstrb, exp_wstrb);
                    if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
                    last_maddr  = bus.mem_addr;
                    last_mwdata = bus.mem_wdata;
                    last_mwstrb = bus.mem_wstrb;
                    last_mwe    = bus.mem_we;
                end
                if (bus.out_valid) begin
                    chk("out_rdata", bus.out_rdata, exp_rdata);
                    chk("out_rd", bus.out_rd, exp_rd);
                    chk("out_fault", bus.out_fault, exp_fault);
                    last_ordata = bus.out_rdata;
                    last_ofault = bus.out_fault;
                end
            end
        end
    end

    // One full transaction: gd = grant delay, rvd = response delay (>=TO: never), rdy = ready delay.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic [2:0] op, input logic [4:0] rd, input logic [31:0] word,
                           input int gd, input int rvd, input int rdy);
        int  exp_lat;
        bit  seen;
        model(a, wd, we, op, rd, word, rvd);
        exp_lat = !exp_bus ? 1 : (2 + gd + ((rvd < TO) ? rvd + 1 : TO));
        last_maddr = 32'hDEADBEEF; last_mwdata = 32'hDEADBEEF; last_mwstrb = 4'h0;
        last_mwe = 1'b0; last_ordata = 32'hDEADBEEF; last_ofault = 1'bx;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_addr = a; bus.in_wdata = wd;
        bus.in_we = we; bus.in_op = op; bus.in_rd = rd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_addr = $urandom; bus.in_wdata = $urandom; bus.in_we = 1'($urandom);
        bus.in_op = 3'($urandom); bus.in_rd = 5'($urandom);
        busy = 1'b1;
        req_cnt = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            bus.mem_gnt = exp_bus && (c == 1 + gd);
            if (exp_bus && rvd < TO && c == 2 + gd + rvd) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
            end else if (c <= 1 + gd) begin
                bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            end else begin
                bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                chk("latency", c, exp_lat);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) chk("out_valid_wait", 32'd0, 32'd1);
        for (int k = 0; k <= rdy; k++) begin
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            bus.out_ready = (k == rdy);
            @(negedge clk);
            chk("out_hold", bus.out_valid, 1'b1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        busy = 1'b0;
        chk("req_cycles", req_cnt, exp_bus ? gd + 1 : 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_addr = 0; bus.in_wdata = 0; bus.in_we = 0;
        bus.in_op = 0; bus.in_rd = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
        bus.mem_rdata = 0; bus.out_ready = 0;
        #2;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_fault", bus.out_fault, 1'b0);
        chk("rst_out_rdata", bus.out_rdata, 32'h0);
        chk("rst_out_rd", bus.out_rd, 5'h0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // lb from top byte, fastest bus
        run_txn(32'h80000003, 32'h0, 1'b0, 3'b000, 5'd7, 32'h8A000000, 0, 0, 0);
        chk("lb_lit_rdata", last_ordata, 32'hFFFFFF8A);
        chk("lb_lit_fault", last_ofault, 1'b0);
        // sh to upper half
        run_txn(32'h80000002, 32'h1234ABCD, 1'b1, 3'b001, 5'd3, 32'h55AA55AA, 0, 1, 0);
        chk("sh_lit_wdata", last_mwdata, 32'hABCD0000);
        chk("sh_lit_wstrb", last_mwstrb, 4'b1100);
        chk("sh_lit_we", last_mwe, 1'b1);
        chk("sh_lit_rdata", last_ordata, 32'h0);
        // lw with slow grant and stalled writeback
        run_txn(32'h10000004, 32'h0, 1'b0, 3'b010, 5'd9, 32'hCAFEF00D, 4, 1, 2);
        chk("lw_lit_rdata", last_ordata, 32'hCAFEF00D);
        // lhu with no response: timeout
        run_txn(32'h20000002, 32'h0, 1'b0, 3'b101, 5'd4, 32'h12345678, 0, 99, 0);
        chk("to_lit_fault", last_ofault, 1'b1);
        chk("to_lit_rdata", last_ordata, 32'h0);
        // response in the last allowed RESP cycle still succeeds
        run_txn(32'h20000002, 32'h0, 1'b0, 3'b101, 5'd4, 32'h8765FFFF, 1, TO - 1, 0);
        chk("late_lit_rdata", last_ordata, 32'h00008765);
        // misaligned word
        run_txn(32'h80000001, 32'h0, 1'b0, 3'b010, 5'd2, 32'hA5A5A5A5, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_lit_fault", last_ofault, 1'b1);
        chk("mis_lit_noreq", req_cnt, 0);
`else
        chk("mis_lit_addr", last_maddr, 32'h80000000);
        chk("mis_lit_rdata", last_ordata, 32'hA5A5A5A5);
`endif
        // illegal ops: reserved funct3 and unsigned store
        run_txn(32'h0, 32'h0, 1'b0, 3'b011, 5'd1, 32'h0, 0, 0, 1);
        chk("ill_lit_fault", last_ofault, 1'b1);
        run_txn(32'h4, 32'hFF, 1'b1, 3'b100, 5'd1, 32'h0, 0, 0, 0);
        chk("sbu_lit_fault", last_ofault, 1'b1);
        // lbu with rd=0 still goes to the bus
        run_txn(32'h00000001, 32'h0, 1'b0, 3'b100, 5'd0, 32'h0000F000, 0, 0, 0);
        chk("lbu_lit_rdata", last_ordata, 32'h000000F0);

        for (int i = 0; i < 150; i++) begin
            int r, rvd;
            r = $urandom % 10;
            rvd = (r == 0) ? 99 : (r == 1) ? TO - 1 : int'($urandom % 4);
            run_txn($urandom, $urandom, 1'($urandom), 3'($urandom), 5'($urandom), $urandom,
                    $urandom % 4, rvd, $urandom % 3);
        end

        // reset during REQ and during RESP
        chk_on = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_addr = 32'h40; bus.in_we = 1'b0;
        bus.in_op = 3'b010; bus.in_rd = 5'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_pre", bus.mem_req, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", bus.mem_req, 1'b0);
        chk("rst_req_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_ovalid", bus.out_valid, 1'b0);
        chk("rst_resp_rd", bus.out_rd, 5'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13572468;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("late_rv_ready", bus.in_ready, 1'b1);
            chk("late_rv_ovalid", bus.out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
